masked_rr_arbiter: RTL and testbench

- Round-robin request/grant arbiter over up to MAX_CHAN channel slots.
- Only slots with g < NUM_CHAN and CHAN_MASK[g] == 1 are live. Per-slot logic sits in a generate-for loop over all MAX_CHAN slots, with a generate-if on that condition.
- Each live slot keeps a saturating grant counter.
- Compilation-plus-simulation block in the regression suite. It exercises parametrised per-bit generate gating together with real sequential arbitration.

---
 rtl/masked_arb_pkg.sv | 51 +++++
 rtl/masked_rr_arbiter_if.sv | 38 +++
 rtl/masked_arb_chan.sv | 38 +++
 rtl/masked_rr_arbiter.sv | 116 +++++++++++
 tb/tb_masked_rr_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/masked_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : masked_arb_pkg
// Brief    : Shared types, default sizes and round-robin winner search for
//            the masked round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package masked_arb_pkg;

  localparam int c_DEF_MAX_CHAN = 8;
  localparam int c_DEF_CNT_W    = 8;

  // Upper bound on physical slots the winner search can scan.
  localparam int c_ARB_LIMIT = 32;
  localparam int c_ARB_LW    = 5;
  localparam int c_IDX_W     = 6;

  typedef logic [c_IDX_W-1:0] arb_idx_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // First set bit of req_live strictly after ptr, wrapping modulo nslots.
  // Returns ptr unchanged when nothing is requesting.
  function automatic arb_idx_t next_live(
    input arb_idx_t                 ptr,
    input logic [c_ARB_LIMIT-1:0]   req_live,
    input int                       nslots
  );
    int   idx;
    logic found;
    next_live = ptr;
    found     = 1'b0;
    for (int k = 1; k <= c_ARB_LIMIT; k++) begin
      if (!found && (k <= nslots)) begin
        idx = int'(ptr) + k;
        if (idx >= nslots) begin
          idx = idx - nslots;
        end
        if (req_live[idx[c_ARB_LW-1:0]]) begin
          next_live = arb_idx_t'(idx);
          found     = 1'b1;
        end
      end
    end
  endfunction

endpackage : masked_arb_pkg
`default_nettype wire

// File: rtl/masked_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : masked_rr_arbiter_if
// Brief    : Request/grant bundle between requesters (master) and the
//            arbiter (slave), including the flattened grant counters.
// Revision : 1.0 - initial release
// ============================================================================
interface masked_rr_arbiter_if
  import masked_arb_pkg::*;
#(
  parameter int MAX_CHAN = c_DEF_MAX_CHAN,
  parameter int CNT_W    = c_DEF_CNT_W
);

  logic [MAX_CHAN-1:0]       req;
  logic                      done;
  logic [MAX_CHAN-1:0]       grant;
  logic                      busy;
  logic [MAX_CHAN*CNT_W-1:0] cnt_flat;

  modport master (
    output req,
    output done,
    input  grant,
    input  busy,
    input  cnt_flat
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output busy,
    output cnt_flat
  );

endinterface : masked_rr_arbiter_if
`default_nettype wire

// File: rtl/masked_arb_chan.sv
`default_nettype none
// ============================================================================
// Module   : masked_arb_chan
// Brief    : One live arbitration slot: qualified request and a saturating
//            grant counter.
// Revision : 1.0 - initial release
// ============================================================================
module masked_arb_chan
  import masked_arb_pkg::*;
#(
  parameter int CNT_W = c_DEF_CNT_W
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             req,
  input  wire logic             inc,
  output logic                  req_q,
  output logic [CNT_W-1:0]      cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;

  assign req_q = req;
  assign w_sat = &r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (inc && !w_sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule : masked_arb_chan
`default_nettype wire

// File: rtl/masked_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : masked_rr_arbiter
// Brief    : Round-robin request/grant arbiter over MAX_CHAN slots, of which
//            only (g < NUM_CHAN && CHAN_MASK[g]) are built.
// Revision : 1.0 - initial release
// ============================================================================
module masked_rr_arbiter
  import masked_arb_pkg::*;
#(
  parameter int                  MAX_CHAN  = c_DEF_MAX_CHAN,
  parameter int                  NUM_CHAN  = 4,
  parameter logic [MAX_CHAN-1:0] CHAN_MASK = {MAX_CHAN{1'b1}},
  parameter int                  CNT_W     = c_DEF_CNT_W
) (
  input  wire logic               clk,
  input  wire logic               reset,
  masked_rr_arbiter_if.slave      bus
);

  arb_state_t                r_state;
  arb_state_t                w_state_nxt;
  logic [MAX_CHAN-1:0]       r_grant;
  logic [MAX_CHAN-1:0]       w_grant_nxt;
  arb_idx_t                  r_ptr;
  arb_idx_t                  w_ptr_nxt;
  arb_idx_t                  w_win;
  logic [MAX_CHAN-1:0]       w_req_live;
  logic [c_ARB_LIMIT-1:0]    w_req_pad;
  logic                      w_any;
  logic                      w_fire;
  logic [MAX_CHAN-1:0]       w_grant_out;
  logic [MAX_CHAN*CNT_W-1:0] w_cnt_flat;

  // Slot liveness is resolved at elaboration; dead slots get no logic at all.
  for (genvar g = 0; g < MAX_CHAN; g++) begin : g_slot
    if ((g < NUM_CHAN) && CHAN_MASK[g]) begin : g_live
      logic [CNT_W-1:0] w_cnt;
      logic             w_inc;

      assign w_inc = w_fire && (w_win == arb_idx_t'(g));

      masked_arb_chan #(
        .CNT_W (CNT_W)
      ) u_chan (
        .clk   (clk),
        .reset (reset),
        .req   (bus.req[g]),
        .inc   (w_inc),
        .req_q (w_req_live[g]),
        .cnt   (w_cnt)
      );

      assign w_grant_out[g]                = r_grant[g];
      assign w_cnt_flat[g*CNT_W +: CNT_W]  = w_cnt;
    end else begin : g_dead
      assign w_req_live[g]                 = 1'b0;
      assign w_grant_out[g]                = 1'b0;
      assign w_cnt_flat[g*CNT_W +: CNT_W]  = '0;
    end
  end

  always_comb begin
    w_req_pad                 = '0;
    w_req_pad[MAX_CHAN-1:0]   = w_req_live;
  end

  assign w_any = |w_req_live;
  assign w_win = next_live(r_ptr, w_req_pad, MAX_CHAN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= arb_idx_t'(MAX_CHAN - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_fire      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_fire      = 1'b1;
          w_grant_nxt = MAX_CHAN'(1) << w_win;
          w_ptr_nxt   = w_win;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        // Grant is held until explicit release; req changes are ignored here.
        if (bus.done) begin
          w_grant_nxt = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.grant    = w_grant_out;
  assign bus.busy     = (r_state == GRANT);
  assign bus.cnt_flat = w_cnt_flat;

endmodule : masked_rr_arbiter
`default_nettype wire

// File: tb/tb_masked_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_masked_rr_arbiter
// Brief    : Scoreboarded bench over five parameterisations of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_masked_rr_arbiter;

  logic       clk;
  logic       reset;
  int         sel;
  logic [7:0] drv_req;
  logic       drv_done;

  logic [7:0] sg;
  logic       sb;
  int         sc [8];

  int n_cmp;
  int n_bad;

  logic [7:0] exp_q [$];
  int         cnt_q [$];

  masked_rr_arbiter_if #(.MAX_CHAN(8), .CNT_W(8)) ifa ();
  masked_rr_arbiter_if #(.MAX_CHAN(8), .CNT_W(8)) ifb ();
  masked_rr_arbiter_if #(.MAX_CHAN(8), .CNT_W(8)) ifc ();
  masked_rr_arbiter_if #(.MAX_CHAN(8), .CNT_W(2)) ifd ();
  masked_rr_arbiter_if #(.MAX_CHAN(8), .CNT_W(8)) ife ();

  masked_rr_arbiter #(.MAX_CHAN(8), .NUM_CHAN(2), .CHAN_MASK(8'h03), .CNT_W(8))
    u_a (.clk(clk), .reset(reset), .bus(ifa));
  masked_rr_arbiter #(.MAX_CHAN(8), .NUM_CHAN(4), .CHAN_MASK(8'hF5), .CNT_W(8))
    u_b (.clk(clk), .reset(reset), .bus(ifb));
  masked_rr_arbiter #(.MAX_CHAN(8), .NUM_CHAN(0), .CHAN_MASK(8'hFF), .CNT_W(8))
    u_c (.clk(clk), .reset(reset), .bus(ifc));
  masked_rr_arbiter #(.MAX_CHAN(8), .NUM_CHAN(1), .CHAN_MASK(8'h01), .CNT_W(2))
    u_d (.clk(clk), .reset(reset), .bus(ifd));
  masked_rr_arbiter #(.MAX_CHAN(8), .NUM_CHAN(4), .CHAN_MASK(8'hFF), .CNT_W(8))
    u_e (.clk(clk), .reset(reset), .bus(ife));

  assign ifa.req  = (sel == 0) ? drv_req  : 8'h00;
  assign ifa.done = (sel == 0) ? drv_done : 1'b0;
  assign ifb.req  = (sel == 1) ? drv_req  : 8'h00;
  assign ifb.done = (sel == 1) ? drv_done : 1'b0;
  assign ifc.req  = (sel == 2) ? drv_req  : 8'h00;
  assign ifc.done = (sel == 2) ? drv_done : 1'b0;
  assign ifd.req  = (sel == 3) ? drv_req  : 8'h00;
  assign ifd.done = (sel == 3) ? drv_done : 1'b0;
  assign ife.req  = (sel == 4) ? drv_req  : 8'h00;
  assign ife.done = (sel == 4) ? drv_done : 1'b0;

  // Observation mux: the instance under test is chosen by sel.
  always_comb begin
    sg = 8'h00;
    sb = 1'b0;
    for (int g = 0; g < 8; g++) sc[g] = 0;
    case (sel)
      0: begin
        sg = ifa.grant; sb = ifa.busy;
        for (int g = 0; g < 8; g++) sc[g] = int'(ifa.cnt_flat[g*8 +: 8]);
      end
      1: begin
        sg = ifb.grant; sb = ifb.busy;
        for (int g = 0; g < 8; g++) sc[g] = int'(ifb.cnt_flat[g*8 +: 8]);
      end
      2: begin
        sg = ifc.grant; sb = ifc.busy;
        for (int g = 0; g < 8; g++) sc[g] = int'(ifc.cnt_flat[g*8 +: 8]);
      end
      3: begin
        sg = ifd.grant; sb = ifd.busy;
        for (int g = 0; g < 8; g++) sc[g] = int'(ifd.cnt_flat[g*2 +: 2]);
      end
      default: begin
        sg = ife.grant; sb = ife.busy;
        for (int g = 0; g < 8; g++) sc[g] = int'(ife.cnt_flat[g*8 +: 8]);
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drv_req  = 8'h00;
    drv_done = 1'b0;
    reset    = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
  endtask

  // Waits (bounded) for a grant to appear; lat counts edges taken.
  task automatic grant_cycle(output logic [7:0] g, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (sg == 8'h00 && lat < 8);
    g = sg;
  endtask

  task automatic release_grant;
    drv_done = 1'b1;
    tick();
    drv_done = 1'b0;
  endtask

  task automatic test_reset;
    int s;
    sel = 4;
    do_reset();
    s = 0;
    for (int g = 0; g < 8; g++) s += sc[g];
    n_cmp++;
    if (sg !== 8'h00) begin
      n_bad++; $display("FAIL reset_grant: got %h expected 00", sg);
    end
    n_cmp++;
    if (sb !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: got %b expected 0", sb);
    end
    n_cmp++;
    if (s != 0) begin
      n_bad++; $display("FAIL reset_cnt: got sum %0d expected 0", s);
    end
  endtask

  task automatic test_alternate;
    logic [7:0] g;
    logic [7:0] e;
    int lat;
    int s;
    sel = 0;
    do_reset();
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    drv_req = 8'h03;
    for (int i = 0; i < 4; i++) begin
      grant_cycle(g, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e || lat != 1 || sb !== 1'b1) begin
        n_bad++;
        $display("FAIL alt_grant[%0d]: got %h busy %b after %0d edges, expected %h busy 1 after 1", i, g, sb, lat, e);
      end
      release_grant();
      n_cmp++;
      if (sg !== 8'h00 || sb !== 1'b0) begin
        n_bad++; $display("FAIL alt_release[%0d]: got grant %h busy %b expected 00/0", i, sg, sb);
      end
    end
    drv_req = 8'h00;
    s = 0;
    for (int k = 2; k < 8; k++) s += sc[k];
    n_cmp++;
    if (sc[0] != 2 || sc[1] != 2 || s != 0) begin
      n_bad++; $display("FAIL alt_cnt: got %0d,%0d,rest %0d expected 2,2,rest 0", sc[0], sc[1], s);
    end
  endtask

  task automatic test_masked;
    logic [7:0] g;
    logic [7:0] e;
    int lat;
    int s;
    sel = 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h01); exp_q.push_back(8'h04);
    end
    drv_req = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      grant_cycle(g, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e || lat != 1) begin
        n_bad++; $display("FAIL mask_grant[%0d]: got %h after %0d edges, expected %h after 1", i, g, lat, e);
      end
      release_grant();
    end
    drv_req = 8'h00;
    s = sc[1] + sc[3] + sc[4] + sc[5] + sc[6] + sc[7];
    n_cmp++;
    if (sc[0] != 3 || sc[2] != 3 || s != 0) begin
      n_bad++; $display("FAIL mask_cnt: got %0d,%0d,rest %0d expected 3,3,rest 0", sc[0], sc[2], s);
    end
  endtask

  task automatic test_no_live;
    int s;
    int bad;
    sel = 2;
    do_reset();
    drv_req = 8'hFF;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      drv_done = (i == 10);
      tick();
      s = 0;
      for (int g = 0; g < 8; g++) s += sc[g];
      n_cmp++;
      if (sg !== 8'h00 || sb !== 1'b0 || s != 0) begin
        n_bad++; $display("FAIL nolive[%0d]: got grant %h busy %b cnt %0d expected 00/0/0", i, sg, sb, s);
      end
    end
    drv_done = 1'b0;
    drv_req  = 8'h00;
  endtask

  task automatic test_saturate;
    logic [7:0] g;
    logic [7:0] e;
    int lat;
    int ec;
    sel = 3;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'h01);
      cnt_q.push_back((i > 3) ? 3 : i);
    end
    drv_req = 8'h01;
    for (int i = 0; i < 5; i++) begin
      grant_cycle(g, lat);
      e  = exp_q.pop_front();
      ec = cnt_q.pop_front();
      n_cmp++;
      if (g !== e || lat != 1 || sc[0] != ec) begin
        n_bad++; $display("FAIL sat[%0d]: got grant %h cnt %0d after %0d edges, expected %h cnt %0d after 1", i, g, sc[0], lat, e, ec);
      end
      release_grant();
    end
    drv_req = 8'h00;
  endtask

  task automatic test_wrap;
    logic [7:0] g;
    logic [7:0] e;
    int lat;
    sel = 4;
    do_reset();
    exp_q.push_back(8'h01); exp_q.push_back(8'h08);
    exp_q.push_back(8'h01); exp_q.push_back(8'h08);
    drv_req = 8'h09;
    for (int i = 0; i < 4; i++) begin
      grant_cycle(g, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e || lat != 1) begin
        n_bad++; $display("FAIL wrap_grant[%0d]: got %h after %0d edges, expected %h after 1", i, g, lat, e);
      end
      release_grant();
    end
    drv_req = 8'h00;
  endtask

  task automatic test_reset_mid_grant;
    logic [7:0] g;
    int lat;
    sel = 4;
    do_reset();
    drv_req = 8'h04;
    grant_cycle(g, lat);
    n_cmp++;
    if (g !== 8'h04 || sc[2] != 1) begin
      n_bad++; $display("FAIL rmid_pre: got grant %h cnt2 %0d expected 04 cnt2 1", g, sc[2]);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (sg !== 8'h00 || sb !== 1'b0 || sc[2] != 0) begin
      n_bad++; $display("FAIL rmid_clear: got grant %h busy %b cnt2 %0d expected 00/0/0", sg, sb, sc[2]);
    end
    reset   = 1'b0;
    drv_req = 8'h05;
    grant_cycle(g, lat);
    n_cmp++;
    if (g !== 8'h01 || lat != 1) begin
      n_bad++; $display("FAIL rmid_first: got %h after %0d edges, expected 01 after 1", g, lat);
    end
    drv_req = 8'h00;
    release_grant();
  endtask

  task automatic test_hold;
    sel = 4;
    do_reset();
    drv_req = 8'h02;
    tick();
    drv_req = 8'h00;
    n_cmp++;
    if (sg !== 8'h02 || sb !== 1'b1) begin
      n_bad++; $display("FAIL hold_grant: got %h busy %b expected 02/1", sg, sb);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (sg !== 8'h02 || sb !== 1'b1) begin
        n_bad++; $display("FAIL hold[%0d]: got %h busy %b expected 02/1", i, sg, sb);
      end
    end
    release_grant();
    n_cmp++;
    if (sg !== 8'h00 || sb !== 1'b0) begin
      n_bad++; $display("FAIL hold_release: got %h busy %b expected 00/0", sg, sb);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    sel      = 4;
    reset    = 1'b1;
    drv_req  = 8'h00;
    drv_done = 1'b0;
    test_reset();
    test_alternate();
    test_masked();
    test_no_live();
    test_saturate();
    test_wrap();
    test_reset_mid_grant();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule : tb_masked_rr_arbiter
`default_nettype wire
